// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage, instruction memory and the decode stage.
// The master side is the fetch unit; the slave side is its environment.
interface fetch_unit_if #(
  parameter int IMW = 4,
  parameter int IW  = 32,
  parameter int CW  = 16
);
  logic           stall;
  logic           br_taken;
  logic [IMW-1:0] br_target;
  logic           im_cs;
  logic [IMW-1:0] im_addr;
  logic [IW-1:0]  im_data;
  logic [IMW-1:0] pc_out;
  logic [IW-1:0]  if_id_instr;
  logic [IMW-1:0] if_id_pc;
  logic           if_id_valid;
  logic [CW-1:0]  fetch_count;

  modport master (
    input  stall, br_taken, br_target, im_data,
    output im_cs, im_addr, pc_out, if_id_instr, if_id_pc, if_id_valid, fetch_count
  );

  modport slave (
    output stall, br_taken, br_target, im_data,
    input  im_cs, im_addr, pc_out, if_id_instr, if_id_pc, if_id_valid, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue fetch stage: PC, one-deep in-flight tag, a skid register that
// keeps the memory word returned during a stall, and the IF/ID register.
module fetch_unit #(
  parameter int             IMW      = 4,
  parameter int             IW       = 32,
  parameter logic [IMW-1:0] RESET_PC = {IMW{1'b0}},
  parameter int             CW       = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {
    OP_ADVANCE  = 2'd0,
    OP_STALL    = 2'd1,
    OP_REDIRECT = 2'd2
  } op_t;

  localparam logic [IMW-1:0] PC_ONE  = {{(IMW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  op_t            op_s;
  logic [IW-1:0]  instr_s;
  logic [IMW-1:0] pc_r;
  logic [IMW-1:0] f_pc_r;
  logic           f_valid_r;
  logic [IW-1:0]  sk_data_r;
  logic           sk_full_r;
  logic [IW-1:0]  if_id_instr_r;
  logic [IMW-1:0] if_id_pc_r;
  logic           if_id_valid_r;
  logic [CW-1:0]  fetch_count_r;

  // Redirect outranks stall; everything else advances.
  always_comb begin
    op_s = OP_ADVANCE;
    if (bus.br_taken) begin
      op_s = OP_REDIRECT;
    end else if (bus.stall) begin
      op_s = OP_STALL;
    end else begin
      op_s = OP_ADVANCE;
    end
  end

  // A parked skid word is the in-flight instruction; memory output is stale then.
  always_comb begin
    instr_s = bus.im_data;
    if (sk_full_r) begin
      instr_s = sk_data_r;
    end else begin
      instr_s = bus.im_data;
    end
  end

  // PC, in-flight tag and skid register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r      <= RESET_PC;
      f_pc_r    <= {IMW{1'b0}};
      f_valid_r <= 1'b0;
      sk_data_r <= {IW{1'b0}};
      sk_full_r <= 1'b0;
    end else begin
      case (op_s)
        OP_ADVANCE: begin
          pc_r      <= pc_r + PC_ONE;
          f_pc_r    <= pc_r;
          f_valid_r <= 1'b1;
          sk_full_r <= 1'b0;
        end
        OP_STALL: begin
          if (f_valid_r && !sk_full_r) begin
            sk_data_r <= bus.im_data;
            sk_full_r <= 1'b1;
          end
        end
        OP_REDIRECT: begin
          pc_r      <= bus.br_target;
          f_valid_r <= 1'b0;
          sk_full_r <= 1'b0;
        end
        default: begin
          pc_r      <= RESET_PC;
          f_valid_r <= 1'b0;
          sk_full_r <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register and delivered-instruction counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_id_instr_r <= {IW{1'b0}};
      if_id_pc_r    <= {IMW{1'b0}};
      if_id_valid_r <= 1'b0;
      fetch_count_r <= {CW{1'b0}};
    end else begin
      case (op_s)
        OP_ADVANCE: begin
          if_id_instr_r <= instr_s;
          if_id_pc_r    <= f_pc_r;
          if_id_valid_r <= f_valid_r;
          if (f_valid_r) begin
            fetch_count_r <= fetch_count_r + CNT_ONE;
          end
        end
        OP_STALL: begin
          if_id_valid_r <= if_id_valid_r;
        end
        OP_REDIRECT: begin
          if_id_valid_r <= 1'b0;
        end
        default: begin
          if_id_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Chip select must fall the instant reset is asserted, so it is not registered.
  always_comb begin
    bus.im_cs = 1'b0;
    if (reset_n && (!bus.stall || bus.br_taken)) begin
      bus.im_cs = 1'b1;
    end else begin
      bus.im_cs = 1'b0;
    end
  end

  assign bus.im_addr     = pc_r;
  assign bus.pc_out      = pc_r;
  assign bus.if_id_instr = if_id_instr_r;
  assign bus.if_id_pc    = if_id_pc_r;
  assign bus.if_id_valid = if_id_valid_r;
  assign bus.fetch_count = fetch_count_r;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- IMW, 4, PC / instruction-memory address width.
- IW, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- CW, 16, delivered-instruction counter width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on its rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- stall, in, 1, hold the pipeline.
- br_taken, in, 1, redirect the PC.
- br_target, in, IMW, redirect address.
- im_cs, out, 1, instruction-memory chip select.
- im_addr, out, IMW, instruction-memory address.
- im_data, in, IW, memory read data; valid exactly one cycle after im_cs=1.
- pc_out, out, IMW, current fetch PC.
- if_id_instr, out, IW, IF/ID instruction.
- if_id_pc, out, IMW, IF/ID instruction address.
- if_id_valid, out, 1, IF/ID entry valid.
- fetch_count, out, CW, delivered-instruction count.

Function
REQ-003 Internal state SHALL be pc_q, in-flight tag (f_pc, f_valid), skid register (sk_data, sk_full) and the IF/ID register.
REQ-004 im_addr SHALL equal pc_q combinationally; pc_out SHALL equal pc_q.
REQ-005 im_cs SHALL be 1 when out of reset and stall=0 or br_taken=1, else 0.
REQ-006 Normal advance (stall=0, br_taken=0): pc_q <= pc_q+1 mod 2^IMW; f_pc <= pc_q; f_valid <= 1.
- The IF/ID register captures {instr, f_pc, f_valid}.
- instr is sk_data if sk_full, else im_data.
- sk_full <= 0.
REQ-007 Latency from pc_q=A to if_id_pc=A with if_id_valid=1 SHALL be 2 cycles with no stall or redirect, with one instruction delivered per cycle thereafter.
REQ-008 Stall (stall=1, br_taken=0): pc_q, f_pc, f_valid and the IF/ID register SHALL hold.
- In the first stall cycle with f_valid=1 and sk_full=0: sk_data <= im_data and sk_full <= 1.
- im_data is ignored in later stall cycles.
REQ-009 Redirect (br_taken=1) SHALL take priority over stall:
- pc_q <= br_target; f_valid <= 0; sk_full <= 0; if_id_valid <= 0.
- if_id_instr and if_id_pc hold.
REQ-010 After a redirect to T with stall=0, if_id_pc=T with if_id_valid=1 SHALL appear 2 cycles later.
REQ-011 br_taken asserted on consecutive cycles SHALL apply each target; only the last target is fetched.
REQ-012 PC wrap SHALL be silent: pc_q=2^IMW-1 advances to 0.
REQ-013 fetch_count SHALL increment by 1, mod 2^CW, on each cycle where IF/ID loads an entry with valid=1. Held entries during stall SHALL not count.
REQ-014 No instruction SHALL be duplicated or dropped across any stall length, including stall held for 1 cycle or for 2^IMW+ cycles.

Reset
REQ-015 reset_n=0 SHALL asynchronously set:
- pc_q=RESET_PC; f_valid=0; sk_full=0.
- if_id_valid=0; if_id_instr=0; if_id_pc=0.
- fetch_count=0; im_cs=0.
REQ-016 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state. The first fetch after release SHALL be at RESET_PC on the first rising edge with reset_n=1.
REQ-017 stall and br_taken SHALL be ignored while reset_n=0.

Verification (IMW=4, RESET_PC=0, memory word k = 32'hA000_0000+k)
REQ-018 Reset release, then 6 free cycles -> if_id_pc sequence 0,1,2,3 starting on cycle 2; if_id_instr=A000_0000+pc; fetch_count=4 after cycle 5.
REQ-019 stall=1 for 3 cycles when if_id_pc=2 -> IF/ID holds pc 2 and pc_out holds 4. After release, if_id_pc runs 3,4,5 with no gap or repeat, and fetch_count excludes the held cycles.
REQ-020 br_taken=1, br_target=9 while pc_q=5 -> if_id_valid=0 next cycle, and the next valid if_id_pc values are 9,10. Instructions at pc 4 and 5 are never delivered.
REQ-021 Free run from pc 14 -> if_id_pc sequence 14,15,0,1; fetch_count keeps incrementing.
REQ-022 stall=1 and br_taken=1 (target 3) in the same cycle -> redirect wins; if_id_pc=3 appears 2 cycles after stall drops.
REQ-023 reset_n pulsed low for 1 ps mid-stall with sk_full=1 -> all outputs zero immediately; after release the fetch restarts at pc 0 with no stale instruction delivered.
